keypad_lock_ctrl: RTL
=====================

KEYPAD_LOCK_CTRL -- requirements
Module: keypad_lock_ctrl

Interface
- REQ-001: Parameter OPEN_CYCLES, default 16'd1000, sets how many cycles the OPEN state lasts.
- REQ-002: Parameter FAIL_CYCLES, default 16'd8, sets how many cycles the FAIL state lasts.
- REQ-003: Parameter LOCK_CYCLES, default 16'd5000, sets how many cycles the LOCKOUT state lasts.
- REQ-004: Parameter RST_CODE, default 16'h1234, is the passcode loaded at reset.
- REQ-005: Port clk, input, 1 bit, is the single clock; all logic is on its rising edge.
- REQ-006: Port rst, input, 1 bit, is a synchronous, active-high reset.
- REQ-007: Port press, input, 1 bit, is a one-cycle pulse marking a valid key in scan_code.
- REQ-008: Port scan_code, input, 4 bits, is the key code (0-9 digits, A enter, B set-code, F clear, C-E unused).
- REQ-009: Port entry_buf, output, 16 bits, holds the digits collected so far, newest digit in [3:0].
- REQ-010: Port digit_cnt, output, 3 bits, is the number of digits collected (0-4).
- REQ-011: Port state, output, 3 bits, is the FSM state code: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5, SETPW=6.
- REQ-012: Port unlock, output, 1 bit, is high exactly while state is OPEN.
- REQ-013: Port error, output, 1 bit, is high exactly while state is FAIL.
- REQ-014: Port alarm, output, 1 bit, is high exactly while state is LOCKOUT.
- REQ-015: Port fail_cnt, output, 2 bits, counts consecutive failed attempts.

Function
- REQ-016: All outputs SHALL be registered; a key is acted on in its press cycle, and its effect is visible on the next cycle.
- REQ-017: A key is a digit if scan_code <= 9; in every state, a press carrying an undefined key (C-E) SHALL be ignored.
- REQ-018: A digit collected in ENTRY or SETPW SHALL be shifted in: entry_buf = {entry_buf[11:0], scan_code}, and digit_cnt increments.
- REQ-019: A digit arriving while digit_cnt == 4 SHALL be dropped; entry_buf and digit_cnt are unchanged.
- REQ-020: IDLE SHALL behave as follows:
  - digit: collect it (digit_cnt = 1) and go to ENTRY;
  - any other key: ignored.
- REQ-021: ENTRY SHALL behave as follows:
  - F: clear entry_buf and digit_cnt, go to IDLE;
  - A with digit_cnt == 4: go to CHECK;
  - A with digit_cnt < 4: count as a failed attempt, evaluated as in CHECK with mismatch.
- REQ-022: CHECK SHALL last exactly 1 cycle and SHALL always clear entry_buf and digit_cnt on exit.
  - Match (entry_buf == passcode): fail_cnt = 0, go to OPEN.
  - Mismatch, fail_cnt < 2: fail_cnt increments, go to FAIL.
  - Mismatch, fail_cnt == 2: fail_cnt = 3, go to LOCKOUT.
- REQ-023: Timer: a 16-bit counter cleared on entry to OPEN, FAIL or LOCKOUT, incrementing each cycle; the state exits when the timer equals its parameter minus 1, so the state lasts exactly that parameter's number of cycles.
- REQ-024: OPEN SHALL behave as follows:
  - on timeout: go to IDLE;
  - F: go to IDLE immediately;
  - B: go to SETPW with entry_buf and digit_cnt cleared;
  - digits: ignored.
- REQ-025: SETPW SHALL collect digits as ENTRY does and SHALL NOT time out.
  - A with digit_cnt == 4: passcode = entry_buf, go to IDLE.
  - A with digit_cnt < 4, or F: go to IDLE with passcode unchanged.
  - entry_buf and digit_cnt are cleared on exit.
- REQ-026: In FAIL, all keys SHALL be ignored; on timeout the block goes to IDLE.
- REQ-027: In LOCKOUT, all keys SHALL be ignored; on timeout the block goes to IDLE with fail_cnt = 0.
- REQ-028: If a press coincides with a timeout, the timeout SHALL win and the key SHALL be discarded.
- REQ-029: passcode SHALL be an internal 16-bit register, changed only by REQ-025 or reset.
- REQ-030: fail_cnt SHALL saturate at 3 and SHALL be cleared only by a successful CHECK, LOCKOUT exit, or reset.

Reset
- REQ-031: Asserting rst SHALL, on the next rising clk edge, set the following regardless of the current state, including mid-entry, OPEN, SETPW and LOCKOUT:
  - state = IDLE (0), entry_buf = 0, digit_cnt = 0, fail_cnt = 0, timer = 0;
  - unlock = error = alarm = 0;
  - passcode = RST_CODE.
- REQ-032: A press asserted in the same cycle as rst SHALL be ignored.

Verification
- REQ-033: Correct code: keys 1,2,3,4,A → entry_buf = 16'h1234 before A, then CHECK for 1 cycle, then unlock = 1 for exactly 1000 cycles, then IDLE.
- REQ-034: Wrong code three times: 1,2,3,5,A repeated → FAIL (error = 1 for 8 cycles) with fail_cnt = 1, then 2; third attempt → alarm = 1 for 5000 cycles with keys ignored, then IDLE with fail_cnt = 0.
- REQ-035: Short entry and overflow:
  - keys 1,2,A → FAIL, fail_cnt = 1;
  - keys 1,2,3,4,5 → digit_cnt = 4 and entry_buf = 16'h1234 (fifth digit dropped).
- REQ-036: Code change: unlock, then B,9,8,7,6,A → IDLE; then 1,2,3,4,A → FAIL; then 9,8,7,6,A → OPEN.
- REQ-037: Clear and abort:
  - keys 5,F → IDLE with entry_buf = 0;
  - in SETPW, keys 9,F → passcode still 16'h1234.
- REQ-038: Reset mid-operation: rst asserted during LOCKOUT or SETPW → next cycle all outputs at reset values and passcode = 16'h1234; a press coincident with timeout is discarded.

Source files
------------

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: passcode door-lock controller driven by a scanned keypad.
//   Collects up to four digits, compares them against a stored passcode and
//   opens, signals an error, or locks out after three consecutive failures.
//   While open, the passcode can be replaced with a new four-digit code.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   press      in   one-cycle strobe qualifying scan_code
//   scan_code  in   key: 0-9 digit, A enter, B set-code, F clear, C-E unused
//   entry_buf  out  collected digits, newest in [3:0]
//   digit_cnt  out  number of digits collected (0-4)
//   state      out  FSM state code (IDLE=0 .. SETPW=6)
//   unlock     out  high while OPEN
//   error      out  high while FAIL
//   alarm      out  high while LOCKOUT
//   fail_cnt   out  consecutive failed attempts, saturating at 3
module keypad_lock_ctrl #(
  parameter logic [15:0] OPEN_CYCLES = 16'd1000,
  parameter logic [15:0] FAIL_CYCLES = 16'd8,
  parameter logic [15:0] LOCK_CYCLES = 16'd5000,
  parameter logic [15:0] RST_CODE    = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        press,
  input  logic [3:0]  scan_code,
  output logic [15:0] entry_buf,
  output logic [2:0]  digit_cnt,
  output logic [2:0]  state,
  output logic        unlock,
  output logic        error,
  output logic        alarm,
  output logic [1:0]  fail_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5,
    ST_SETPW   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  fail_q, fail_d;
  logic [15:0] code_q, code_d;
  logic [15:0] timer_q, timer_d;
  logic        unlock_q, error_q, alarm_q;

  logic key_digit, key_enter, key_set, key_clear;
  logic timeout;
  logic attempt_fail;
  logic timed_state;

  assign key_digit = press && (scan_code <= 4'd9);
  assign key_enter = press && (scan_code == 4'hA);
  assign key_set   = press && (scan_code == 4'hB);
  assign key_clear = press && (scan_code == 4'hF);

  // Each timed state exits on the last of its cycles; the timer restarts at 0
  // on entry, so the exit compare is against the length minus one.
  always_comb begin
    timeout = 1'b0;
    case (state_q)
      ST_OPEN:    timeout = (timer_q == OPEN_CYCLES - 16'd1);
      ST_FAIL:    timeout = (timer_q == FAIL_CYCLES - 16'd1);
      ST_LOCKOUT: timeout = (timer_q == LOCK_CYCLES - 16'd1);
      default:    timeout = 1'b0;
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    fail_d       = fail_q;
    code_d       = code_q;
    attempt_fail = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_digit) begin
          buf_d   = {12'h000, scan_code};
          cnt_d   = 3'd1;
          state_d = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (key_clear) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (key_enter) begin
          if (cnt_q == 3'd4) state_d = ST_CHECK;
          else               attempt_fail = 1'b1;  // short entry is a wrong code
        end else if (key_digit && cnt_q != 3'd4) begin
          buf_d = {buf_q[11:0], scan_code};
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          fail_d  = 2'd0;
          state_d = ST_OPEN;
        end else begin
          attempt_fail = 1'b1;
        end
      end

      // Timeout is tested first so a key landing on the final cycle is dropped.
      ST_OPEN: begin
        if (timeout || key_clear) begin
          state_d = ST_IDLE;
        end else if (key_set) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_SETPW;
        end
      end

      ST_SETPW: begin
        if (key_enter || key_clear) begin
          if (key_enter && cnt_q == 3'd4) code_d = buf_q;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (key_digit && cnt_q != 3'd4) begin
          buf_d = {buf_q[11:0], scan_code};
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_FAIL: begin
        if (timeout) state_d = ST_IDLE;
      end

      ST_LOCKOUT: begin
        if (timeout) begin
          fail_d  = 2'd0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Shared failed-attempt path for CHECK mismatch and short ENTRY.
    if (attempt_fail) begin
      buf_d = '0;
      cnt_d = '0;
      if (fail_q >= 2'd2) begin
        fail_d  = 2'd3;
        state_d = ST_LOCKOUT;
      end else begin
        fail_d  = fail_q + 2'd1;
        state_d = ST_FAIL;
      end
    end
  end

  assign timed_state = (state_q == ST_OPEN) || (state_q == ST_FAIL) ||
                       (state_q == ST_LOCKOUT);

  always_comb begin
    timer_d = '0;
    if (state_d == state_q && timed_state) timer_d = timer_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      code_q   <= RST_CODE;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      error_q  <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      unlock_q <= (state_d == ST_OPEN);
      error_q  <= (state_d == ST_FAIL);
      alarm_q  <= (state_d == ST_LOCKOUT);
    end
  end

  assign entry_buf = buf_q;
  assign digit_cnt = cnt_q;
  assign state     = state_q;
  assign unlock    = unlock_q;
  assign error     = error_q;
  assign alarm     = alarm_q;
  assign fail_cnt  = fail_q;

endmodule
